// File: rtl/vga_pattern_gen.sv
// Frame pattern generator feeding a memory writer: DATA_DEPTH words per start edge, four patterns.
// Latency: one cycle from wr_en to data_en/dout; wr_en low stalls the frame with dout held.
module vga_pattern_gen #(
    parameter int                DATA_W     = 16,
    parameter int                DATA_DEPTH = 786432,
    parameter int                H_ACTIVE   = 1024,
    parameter int                SPAN_NUM   = 9,
    parameter logic [DATA_W-1:0] BAR_STEP   = 16'h2104,
    parameter int                CHK_SHIFT  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] fill_i,
    input  logic              wr_en,
    output logic              data_en,
    output logic [DATA_W-1:0] dout,
    output logic              busy_o,
    output logic              done_o,
    output logic [15:0]       frame_cnt_o
);
    localparam int IDX_W = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
    localparam int X_W   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int LINES = DATA_DEPTH / H_ACTIVE;
    localparam int Y_W   = (LINES > 1) ? $clog2(LINES) : 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t            state, state_nxt;
    logic              start_q;
    logic              accept, emit, last;
    logic [1:0]        mode_r;
    logic [DATA_W-1:0] fill_r;
    logic [DATA_W-1:0] base;
    logic [IDX_W-1:0]  idx;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [X_W+2:0]    bar;
    logic              chk;
    logic [DATA_W-1:0] pix;

    assign last = (idx == IDX_W'(DATA_DEPTH - 1));

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        emit      = 1'b0;
        case (state)
            IDLE: begin
                if (start_i && !start_q) begin
                    accept    = 1'b1;
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                // abort wins over a word grant in the same cycle
                if (abort_i) begin
                    state_nxt = IDLE;
                end else if (wr_en) begin
                    emit = 1'b1;
                    if (last) state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bar = {x, 3'b000} / (X_W + 3)'(H_ACTIVE);
        chk = (|((x >> CHK_SHIFT) & X_W'(1))) ^ (|((y >> CHK_SHIFT) & Y_W'(1)));
        pix = '0;
        case (mode_r)
            2'd0:    pix = base + DATA_W'(idx);
            2'd1:    pix = fill_r;
            2'd2:    pix = DATA_W'(bar) * BAR_STEP;
            default: pix = {DATA_W{chk}};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            start_q     <= 1'b0;
            data_en     <= 1'b0;
            dout        <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            frame_cnt_o <= '0;
            base        <= '0;
            mode_r      <= '0;
            fill_r      <= '0;
            idx         <= '0;
            x           <= '0;
            y           <= '0;
        end else begin
            state   <= state_nxt;
            start_q <= start_i;
            data_en <= emit;
            busy_o  <= (state_nxt != IDLE);
            done_o  <= (state == DONE);
            if (accept) begin
                mode_r <= mode_i;
                fill_r <= fill_i;
                idx    <= '0;
                x      <= '0;
                y      <= '0;
            end
            if (emit) begin
                dout <= pix;
                idx  <= idx + IDX_W'(1);
                if (x == X_W'(H_ACTIVE - 1)) begin
                    x <= '0;
                    y <= y + Y_W'(1);
                end else begin
                    x <= x + X_W'(1);
                end
            end
            if (state == DONE) begin
                frame_cnt_o <= frame_cnt_o + 16'd1;
                if (mode_r == 2'd0) base <= base + DATA_W'(SPAN_NUM);
            end
        end
    end
endmodule
